// File: rtl/intersection_pkg.sv
// Shared types and default timing for the intersection phase sequencer.
package intersection_pkg;

    typedef enum logic [2:0] {
        PhMainGreen  = 3'd0,
        PhMainYellow = 3'd1,
        PhAllRed1    = 3'd2,
        PhSideGreen  = 3'd3,
        PhSideYellow = 3'd4,
        PhAllRed2    = 3'd5,
        PhPedWalk    = 3'd6
    } phase_t;

    localparam int unsigned DefTw       = 6;
    localparam int unsigned DefMainMin  = 20;
    localparam int unsigned DefSideMin  = 5;
    localparam int unsigned DefSideMax  = 12;
    localparam int unsigned DefYellow   = 3;
    localparam int unsigned DefAllRed   = 2;
    localparam int unsigned DefWalk     = 8;

endpackage

// File: rtl/intersection_controller_if.sv
// Request inputs and lamp/status outputs of the intersection controller.
interface intersection_controller_if;

    logic       side_req;
    logic       ped_req;
    logic       main_red;
    logic       main_yellow;
    logic       main_green;
    logic       side_red;
    logic       side_yellow;
    logic       side_green;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    // master: sensors/buttons side; slave: the controller.
    modport master (
        output side_req, ped_req,
        input  main_red, main_yellow, main_green, side_red, side_yellow, side_green,
        input  walk, ped_pending, phase
    );

    modport slave (
        input  side_req, ped_req,
        output main_red, main_yellow, main_green, side_red, side_yellow, side_green,
        output walk, ped_pending, phase
    );

endinterface

// File: rtl/dwell_timer.sv
// Cycles-in-phase counter: synchronous clear, saturates at all-ones.
module dwell_timer #(
    parameter int unsigned TW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    output logic [TW-1:0] cnt
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection phase sequencer with all-red clearance.
// Pedestrian phase is built only when INTERSECTION_PED_EN is defined.
module intersection_controller
    import intersection_pkg::*;
#(
    parameter int unsigned TW         = DefTw,
    parameter int unsigned T_MAIN_MIN = DefMainMin,
    parameter int unsigned T_SIDE_MIN = DefSideMin,
    parameter int unsigned T_SIDE_MAX = DefSideMax,
    parameter int unsigned T_YELLOW   = DefYellow,
    parameter int unsigned T_ALLRED   = DefAllRed,
    parameter int unsigned T_WALK     = DefWalk
) (
    input logic                      clk,
    input logic                      reset,
    intersection_controller_if.slave bus
);

    localparam int unsigned TMax = (1 << TW) - 1;

    if (T_MAIN_MIN < 1 || T_MAIN_MIN > TMax || T_SIDE_MIN < 1 || T_SIDE_MAX > TMax ||
        T_SIDE_MIN > T_SIDE_MAX || T_YELLOW < 1 || T_YELLOW > TMax ||
        T_ALLRED < 1 || T_ALLRED > TMax || T_WALK < 1 || T_WALK > TMax) begin : g_param_check
        $error("intersection_controller: duration parameter out of range");
    end

    localparam logic [TW-1:0] MainMinM1 = TW'(T_MAIN_MIN - 1);
    localparam logic [TW-1:0] SideMinM1 = TW'(T_SIDE_MIN - 1);
    localparam logic [TW-1:0] SideMaxM1 = TW'(T_SIDE_MAX - 1);
    localparam logic [TW-1:0] YellowM1  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] AllRedM1  = TW'(T_ALLRED - 1);
`ifdef INTERSECTION_PED_EN
    localparam logic [TW-1:0] WalkM1    = TW'(T_WALK - 1);
`endif

    phase_t        phase_q, phase_d;
    logic [TW-1:0] cnt;
    logic          ped_pend;
    logic          main_red_q, main_yellow_q, main_green_q;
    logic          side_red_q, side_yellow_q, side_green_q;

    dwell_timer #(
        .TW(TW)
    ) u_dwell_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (phase_d != phase_q),
        .cnt  (cnt)
    );

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PhMainGreen:  if (cnt >= MainMinM1 && (bus.side_req || ped_pend))
                              phase_d = PhMainYellow;
            PhMainYellow: if (cnt == YellowM1) phase_d = PhMainRedNext();
            PhAllRed1:    if (cnt == AllRedM1) phase_d = ped_pend ? PhPedWalk : PhSideGreen;
            PhSideGreen:  if (cnt == SideMaxM1 || (cnt >= SideMinM1 && !bus.side_req))
                              phase_d = PhSideYellow;
            PhSideYellow: if (cnt == YellowM1) phase_d = PhAllRed2;
            PhAllRed2:    if (cnt == AllRedM1) phase_d = PhMainGreen;
`ifdef INTERSECTION_PED_EN
            PhPedWalk:    if (cnt == WalkM1) phase_d = bus.side_req ? PhSideGreen : PhAllRed2;
`endif
            default:      phase_d = PhAllRed2;
        endcase
    end

    function automatic phase_t PhMainRedNext();
        return PhAllRed1;
    endfunction

    // Lamps are registered from the next phase so they change on the same edge as phase_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PhAllRed2;
            main_red_q    <= 1'b1;
            main_yellow_q <= 1'b0;
            main_green_q  <= 1'b0;
            side_red_q    <= 1'b1;
            side_yellow_q <= 1'b0;
            side_green_q  <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            main_green_q  <= (phase_d == PhMainGreen);
            main_yellow_q <= (phase_d == PhMainYellow);
            main_red_q    <= !(phase_d == PhMainGreen || phase_d == PhMainYellow);
            side_green_q  <= (phase_d == PhSideGreen);
            side_yellow_q <= (phase_d == PhSideYellow);
            side_red_q    <= !(phase_d == PhSideGreen || phase_d == PhSideYellow);
        end
    end

`ifdef INTERSECTION_PED_EN
    logic ped_pending_q, walk_q;

    // Entering the walk phase clears the request even if the button is pressed that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            walk_q <= (phase_d == PhPedWalk);
            if (phase_d == PhPedWalk && phase_q != PhPedWalk) begin
                ped_pending_q <= 1'b0;
            end else if (bus.ped_req && phase_q != PhPedWalk) begin
                ped_pending_q <= 1'b1;
            end
        end
    end

    assign ped_pend        = ped_pending_q;
    assign bus.walk        = walk_q;
    assign bus.ped_pending = ped_pending_q;
`else
    assign ped_pend        = 1'b0;
    assign bus.walk        = 1'b0;
    assign bus.ped_pending = 1'b0;
`endif

    assign bus.phase       = phase_q;
    assign bus.main_red    = main_red_q;
    assign bus.main_yellow = main_yellow_q;
    assign bus.main_green  = main_green_q;
    assign bus.side_red    = side_red_q;
    assign bus.side_yellow = side_yellow_q;
    assign bus.side_green  = side_green_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Self-checking bench for intersection_controller against a cycle-level reference model.
module tb_intersection_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    intersection_controller_if bus ();

    intersection_controller dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef INTERSECTION_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    // {phase, mr, my, mg, sr, sy, sg, walk, ped_pending} for phase 5 right after reset
    localparam logic [10:0] RESET_VEC = 11'b101_100_100_00;

    int n_checks = 0;
    int n_pass   = 0;

    int m_phase;
    int m_cnt;
    bit m_pend;

    logic [10:0] dut_vec;
    assign dut_vec = {bus.phase, bus.main_red, bus.main_yellow, bus.main_green,
                      bus.side_red, bus.side_yellow, bus.side_green, bus.walk, bus.ped_pending};

    function automatic logic [10:0] exp_vec();
        logic [2:0] p;
        p = 3'(m_phase);
        return {p, !(m_phase == 0 || m_phase == 1), m_phase == 1, m_phase == 0,
                !(m_phase == 3 || m_phase == 4), m_phase == 4, m_phase == 3,
                m_phase == 6, m_pend};
    endfunction

    // Reference model: one clock edge of the phase rules with default durations.
    task automatic model_step(input bit side, input bit ped);
        int nx;
        nx = m_phase;
        case (m_phase)
            0: if (m_cnt >= 19 && (side || (PED && m_pend))) nx = 1;
            1: if (m_cnt == 2) nx = 2;
            2: if (m_cnt == 1) nx = (PED && m_pend) ? 6 : 3;
            3: if (m_cnt == 11 || (m_cnt >= 4 && !side)) nx = 4;
            4: if (m_cnt == 2) nx = 5;
            5: if (m_cnt == 1) nx = 0;
            6: if (m_cnt == 7) nx = side ? 3 : 5;
            default: nx = 5;
        endcase
        if (PED) begin
            if (nx == 6 && m_phase != 6) m_pend = 1'b0;
            else if (ped && m_phase != 6) m_pend = 1'b1;
        end
        m_cnt   = (nx != m_phase) ? 0 : ((m_cnt < 63) ? m_cnt + 1 : 63);
        m_phase = nx;
    endtask

    task automatic tick(input bit side, input bit ped);
        bus.side_req = side;
        bus.ped_req  = ped;
        @(posedge clk);
        model_step(side, ped);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        m_phase      = 5;
        m_cnt        = 0;
        m_pend       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.side_req = 1'b0;
        bus.ped_req  = 1'b0;
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL reset_async: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL reset_held: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
    endtask

    task automatic test_idle();
        int exp_ph;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            exp_ph = (i < 2) ? 5 : 0;
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL idle_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            n_checks++;
            if (bus.phase !== 3'(exp_ph))
                $display("FAIL idle_phase cycle %0d: got %0d expected %0d", i, bus.phase, exp_ph);
            else n_pass++;
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_side_max();
        int rp[$];
        int rl[$];
        int ep[8] = '{5, 0, 1, 2, 3, 4, 5, 0};
        int el[7] = '{2, 20, 3, 2, 12, 3, 2};
        do_reset();
        for (int i = 0; i < 50; i++) begin
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL side_max_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            if (rp.size() == 0 || rp[$] != int'(bus.phase)) begin
                rp.push_back(int'(bus.phase));
                rl.push_back(1);
            end else rl[$]++;
            tick(i >= 7, 1'b0);
        end
        n_checks++;
        if (rp.size() < 8) $display("FAIL side_max_runs: got %0d runs expected >= 8", rp.size());
        else begin
            n_pass++;
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (rp[k] != ep[k] || (k < 7 && rl[k] != el[k]))
                    $display("FAIL side_max_run %0d: got phase %0d len %0d expected phase %0d len %0d",
                             k, rp[k], rl[k], ep[k], (k < 7) ? el[k] : 0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_side_min();
        int rp[$];
        int rl[$];
        int ep[8] = '{5, 0, 1, 2, 3, 4, 5, 0};
        int el[7] = '{2, 20, 3, 2, 5, 3, 2};
        bit side = 1'b1;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL side_min_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            if (rp.size() == 0 || rp[$] != int'(bus.phase)) begin
                rp.push_back(int'(bus.phase));
                rl.push_back(1);
            end else rl[$]++;
            if (m_phase == 3 && m_cnt == 2) side = 1'b0;
            tick(side, 1'b0);
        end
        n_checks++;
        if (rp.size() < 8) $display("FAIL side_min_runs: got %0d runs expected >= 8", rp.size());
        else begin
            n_pass++;
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (rp[k] != ep[k] || (k < 7 && rl[k] != el[k]))
                    $display("FAIL side_min_run %0d: got phase %0d len %0d expected phase %0d len %0d",
                             k, rp[k], rl[k], ep[k], (k < 7) ? el[k] : 0);
                else n_pass++;
            end
        end
    endtask

`ifdef INTERSECTION_PED_EN
    task automatic test_ped();
        int rp[$];
        int rl[$];
        int ep[7] = '{5, 0, 1, 2, 6, 5, 0};
        int el[6] = '{2, 20, 3, 2, 8, 2};
        do_reset();
        for (int i = 0; i < 45; i++) begin
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL ped_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            if (i == 6) begin
                n_checks++;
                if (bus.ped_pending !== 1'b1)
                    $display("FAIL ped_latch: got %b expected 1", bus.ped_pending);
                else n_pass++;
            end
            if (rp.size() == 0 || rp[$] != int'(bus.phase)) begin
                rp.push_back(int'(bus.phase));
                rl.push_back(1);
            end else rl[$]++;
            tick(1'b0, i == 5);
        end
        n_checks++;
        if (rp.size() < 7) $display("FAIL ped_runs: got %0d runs expected >= 7", rp.size());
        else begin
            n_pass++;
            for (int k = 0; k < 7; k++) begin
                n_checks++;
                if (rp[k] != ep[k] || (k < 6 && rl[k] != el[k]))
                    $display("FAIL ped_run %0d: got phase %0d len %0d expected phase %0d len %0d",
                             k, rp[k], rl[k], ep[k], (k < 6) ? el[k] : 0);
                else n_pass++;
            end
        end
    endtask
`else
    task automatic test_no_ped();
        do_reset();
        for (int i = 0; i < 200; i++) begin
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL no_ped_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            if (i >= 2) begin
                n_checks++;
                if (bus.phase !== 3'd0 || bus.walk !== 1'b0 || bus.ped_pending !== 1'b0)
                    $display("FAIL no_ped_hold cycle %0d: got phase %0d walk %b pend %b expected 0 0 0",
                             i, bus.phase, bus.walk, bus.ped_pending);
                else n_pass++;
            end
            tick(1'b0, (i % 10) == 0);
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit pulsed = 1'b0;
        bit found  = 1'b0;
        do_reset();
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_phase == 3 && m_cnt == 3) found = 1'b1;
            else begin
                tick(1'b1, (m_phase == 3 && m_cnt == 1 && !pulsed));
                if (m_phase == 3 && m_cnt == 2) pulsed = 1'b1;
            end
        end
        n_checks++;
        if (!found || bus.phase !== 3'd3 || bus.ped_pending !== PED)
            $display("FAIL reset_mid_setup: got phase %0d pend %b expected phase 3 pend %b",
                     bus.phase, bus.ped_pending, PED);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (dut_vec !== RESET_VEC)
            $display("FAIL reset_mid: got %b expected %b", dut_vec, RESET_VEC);
        else n_pass++;
    endtask

    task automatic test_random();
        bit side = 1'b0;
        bit ped;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            n_checks++;
            if (dut_vec !== exp_vec())
                $display("FAIL random_model cycle %0d: got %b expected %b", i, dut_vec, exp_vec());
            else n_pass++;
            if ($urandom_range(7) == 0) side = !side;
            ped = ($urandom_range(29) == 0);
            tick(side, ped);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_side_max();
        test_side_min();
`ifdef INTERSECTION_PED_EN
        test_ped();
`else
        test_no_ped();
`endif
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Phase sequencer for a two-road intersection (main road, side road) with an optional pedestrian crossing. It drives both road light sets and the walk signal from one phase state machine and a shared dwell counter. It decides when each road and the pedestrian crossing get the intersection, with all-red clearance between conflicting phases. It sits above the per-road light outputs and is the only block that changes light state.

## Interface
- `TW`, 6: dwell counter width.
- `T_MAIN_MIN`, 20: minimum main-green dwell, in cycles.
- `T_SIDE_MIN`, 5: minimum side-green dwell, in cycles.
- `T_SIDE_MAX`, 12: maximum side-green dwell, in cycles.
- `T_YELLOW`, 3: yellow dwell (both roads), in cycles.
- `T_ALLRED`, 2: all-red clearance dwell, in cycles.
- `T_WALK`, 8: pedestrian walk dwell, in cycles.
- Legal ranges: every duration is ≥1 and <2^TW; T_SIDE_MIN ≤ T_SIDE_MAX.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `side_req` in 1: side-road vehicle sensor, level, synchronous to clk.
- `ped_req` in 1: pedestrian button, may be a 1-cycle pulse.
- `main_red`, `main_yellow`, `main_green` out 1 each: main-road lamps.
- `side_red`, `side_yellow`, `side_green` out 1 each: side-road lamps.
- `walk` out 1: pedestrian walk lamp.
- `ped_pending` out 1: a pedestrian request is latched and not yet served.
- `phase` out 3: current phase encoding.

## Operation
- Phases and encodings: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6. Encoding 7 is illegal and recovers to ALL_RED_2.
- `cnt` is the number of completed cycles in the current phase. It is 0 on the first cycle of a phase, increments each cycle, saturates at 2^TW−1, and clears on every phase change.
- MAIN_GREEN → MAIN_YELLOW when cnt ≥ T_MAIN_MIN−1 and (side_req or ped_pending). With no requests, MAIN_GREEN is held indefinitely.
- MAIN_YELLOW → ALL_RED_1 when cnt = T_YELLOW−1.
- ALL_RED_1 → PED_WALK if ped_pending, otherwise SIDE_GREEN, when cnt = T_ALLRED−1.
- PED_WALK → SIDE_GREEN if side_req, otherwise ALL_RED_2, when cnt = T_WALK−1.
- SIDE_GREEN → SIDE_YELLOW when cnt = T_SIDE_MAX−1, or when cnt ≥ T_SIDE_MIN−1 and !side_req.
- SIDE_YELLOW → ALL_RED_2 when cnt = T_YELLOW−1.
- ALL_RED_2 → MAIN_GREEN when cnt = T_ALLRED−1.
- Output decode:
  - Each road shows exactly one lamp.
  - main_green/main_yellow are set in phases 0/1 only; main_red is set otherwise.
  - side_green/side_yellow are set in phases 3/4 only; side_red is set otherwise.
  - walk is set in phase 6 only, during which both roads are red.
- Outputs are decoded from the state register only, with no input-to-output path.
- ped_pending:
  - Sets on any cycle with ped_req=1 outside PED_WALK.
  - Clears on the edge that enters PED_WALK. Clear wins over a simultaneous set.
  - ped_req during PED_WALK is ignored.

## Timing
- Reset state: phase=ALL_RED_2, cnt=0, ped_pending=0, main_red=side_red=1, all other outputs 0.
- Reset takes effect immediately and asynchronously, including mid-phase.
- After reset release, ALL_RED_2 lasts T_ALLRED cycles, then MAIN_GREEN.
- Phase dwell equals the stated T exactly. Green dwell is bounded below by the MIN value (and above by T_SIDE_MAX for side green).
- Request latency: side_req or ped_pending sampled at the edge where the exit condition holds causes the phase change on that same edge. Lamps update on that edge, with no extra cycle.
- A ped_req pulse becomes visible on ped_pending one cycle later.

## Configuration
- `INTERSECTION_PED_EN` defined: pedestrian phase present, as described above.
- `INTERSECTION_PED_EN` undefined:
  - ped_req is ignored.
  - ped_pending and walk are tied to 0.
  - PED_WALK is unreachable, and phase 6 recovers to ALL_RED_2.
  - MAIN_GREEN exits on side_req only.
  - T_WALK is unused.

## Structure
- Package `intersection_pkg`: `phase_t` enum (3-bit, encodings above) and default duration constants.
- Sub-module `dwell_timer`: TW-bit counter with synchronous clear and saturation, reset to 0. The controller instantiates it once.

## Test plan
All scenarios use the default parameters.
- Reset release, no requests → ALL_RED_2 for 2 cycles, then MAIN_GREEN (phase=0) held for ≥100 cycles.
- side_req held high from MAIN_GREEN cnt=5 → main green 20 cycles, yellow 3, all-red 2, side green 12 (max), side yellow 3, all-red 2, then MAIN_GREEN.
- side_req high, dropped at SIDE_GREEN cnt=2 → side green exactly 5 cycles, then SIDE_YELLOW.
- ped_req 1-cycle pulse at MAIN_GREEN cnt=3, side_req=0 → ped_pending=1 next cycle; main green 20, yellow 3, all-red 2; PED_WALK 8 cycles with walk=1 and ped_pending=0 from its first cycle; then ALL_RED_2 2 cycles, then MAIN_GREEN.
- reset asserted mid SIDE_GREEN with ped_pending=1 → immediately phase=5, main_red=side_red=1, ped_pending=0, no clock required.
- Macro undefined, ped_req pulsed every 10 cycles with side_req=0 → walk stays 0 and MAIN_GREEN is never left.
